// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue controller: opcode encodings,
// FSM state type, command record and an opcode legality helper.
package alu_issue_pkg;

    localparam int DATA_W    = 16;
    localparam int OP_W      = 4;
    localparam int TAG_W_MAX = 16;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0100;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0110;
    localparam logic [OP_W-1:0] OP_AND = 4'b0111;
    localparam logic [OP_W-1:0] OP_EQ  = 4'b1000;
    localparam logic [OP_W-1:0] OP_NE  = 4'b1001;
    localparam logic [OP_W-1:0] OP_SUB = 4'b1010;
    localparam logic [OP_W-1:0] OP_SLT = 4'b1100;
    localparam logic [OP_W-1:0] OP_SGE = 4'b1101;
    localparam logic [OP_W-1:0] OP_ULT = 4'b1110;
    localparam logic [OP_W-1:0] OP_UGE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP
    } state_t;

    // Command as seen at the FIFO head; tag is widened to the largest
    // supported tag width, only the low TAG_W bits carry information.
    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic [DATA_W-1:0]    a;
        logic [DATA_W-1:0]    b;
        logic [TAG_W_MAX-1:0] tag;
    } cmd_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_XOR, OP_OR, OP_AND, OP_EQ, OP_NE,
            OP_SUB, OP_SLT, OP_SGE, OP_ULT, OP_UGE: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO for queued ALU commands. Pointers wrap modulo DEPTH
// (power of two); a separate occupancy counter tells full from empty.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en;
    logic             pop_en;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;

    // Next pointer and occupancy values.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port.
    // NOTE: the storage array is not reset; empty pointers guard it, and leaving it unreset keeps it mappable to plain RAM/flops without reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: queues commands, issues them one at a time to an
// external combinational ALU, captures the result and holds it until the
// consumer accepts it. Define ALU_ISSUE_STATS_EN to add the stat_ops
// completed-operation counter port.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [15:0]       cmd_a,
    input  logic [15:0]       cmd_b,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [15:0]       alu_a,
    output logic [15:0]       alu_b,
    output logic [3:0]        alu_sel,
    input  logic [15:0]       alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [TAG_W-1:0]  rsp_tag
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]       stat_ops
`endif
);

    localparam int PAY_W = OP_W + 2 * DATA_W + TAG_W;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PAY_W-1:0] fifo_din;
    logic [PAY_W-1:0] fifo_dout;
    cmd_t             head;
    logic             head_legal;
    logic             head_tag_unused;
    logic             rsp_hs;

    state_t            state_q, state_d;
    logic [15:0]       alu_a_q, alu_a_d;
    logic [15:0]       alu_b_q, alu_b_d;
    logic [3:0]        alu_sel_q, alu_sel_d;
    logic              op_err_q, op_err_d;
    logic [TAG_W-1:0]  cmd_tag_q, cmd_tag_d;
    logic [15:0]       rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_err_q, rsp_err_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;

    // A full FIFO refuses commands even when a pop happens the same cycle.
    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && !fifo_full;
    assign fifo_din  = {cmd_op, cmd_a, cmd_b, cmd_tag};

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PAY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_din),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Unpack the FIFO head into the command record.
    always_comb begin
        head     = '0;
        head.op  = fifo_dout[PAY_W-1 -: OP_W];
        head.a   = fifo_dout[TAG_W + 2*DATA_W - 1 -: DATA_W];
        head.b   = fifo_dout[TAG_W + DATA_W - 1 -: DATA_W];
        head.tag = TAG_W_MAX'(fifo_dout[TAG_W-1:0]);
    end

    assign head_legal      = op_is_legal(head.op);
    assign head_tag_unused = |head.tag;
    assign rsp_hs          = (state_q == ST_RESP) && rsp_ready;

    // FSM next state, head pop/load and result capture.
    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        op_err_d     = op_err_q;
        cmd_tag_d    = cmd_tag_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        rsp_tag_d    = rsp_tag_q;
        fifo_pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Illegal opcodes run a harmless ADD on the ALU but report 0.
                rsp_result_d = op_err_q ? 16'h0000 : alu_out;
                rsp_zero_d   = op_err_q || (alu_out == 16'h0000);
                rsp_err_d    = op_err_q;
                rsp_tag_d    = cmd_tag_q;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_ISSUE;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The ALU operand registers double as the issue registers, so they
        // only change when a new command is popped and hold otherwise.
        if (fifo_pop) begin
            alu_a_d   = head.a;
            alu_b_d   = head.b;
            alu_sel_d = head_legal ? head.op : OP_ADD;
            op_err_d  = !head_legal;
            cmd_tag_d = head.tag[TAG_W-1:0];
        end
    end

    // State, issue and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            op_err_q     <= 1'b0;
            cmd_tag_q    <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            op_err_q     <= op_err_d;
            cmd_tag_q    <= cmd_tag_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_tag    = rsp_tag_q;

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] stat_ops_q, stat_ops_d;

    // Completed-operation count, wraps at 16 bits.
    always_comb begin
        stat_ops_d = stat_ops_q;
        if (rsp_hs) begin
            stat_ops_d = stat_ops_q + 16'd1;
        end
    end

    // Completed-operation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q <= '0;
        end else begin
            stat_ops_q <= stat_ops_d;
        end
    end

    assign stat_ops = stat_ops_q;
`else
    logic rsp_hs_unused;
    assign rsp_hs_unused = rsp_hs;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: reset values, a table of directed
// single-command vectors, queue fill/drain, reset mid-operation, a random
// stream against a queue-based reference, and (with ALU_ISSUE_STATS_EN)
// the stat_ops wrap.
module tb_alu_issue_ctrl;

    localparam int FIFO_DEPTH = 4;
    localparam int TAG_W      = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [3:0]        cmd_op = '0;
    logic [15:0]       cmd_a = '0;
    logic [15:0]       cmd_b = '0;
    logic [TAG_W-1:0]  cmd_tag = '0;
    logic [15:0]       alu_a;
    logic [15:0]       alu_b;
    logic [3:0]        alu_sel;
    logic [15:0]       alu_out;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [15:0]       rsp_result;
    logic              rsp_zero;
    logic              rsp_err;
    logic [TAG_W-1:0]  rsp_tag;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0]       stat_ops;
`endif

    int total = 0;
    int bad   = 0;

    logic [3:0] legal_ops [11] = '{4'h0, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9,
                                   4'hA, 4'hC, 4'hD, 4'hE, 4'hF};

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
        logic [15:0] res;
        logic        zero;
        logic        err;
    } vec_t;

    vec_t vecs [14];

    always #5 clk = ~clk;

    // External ALU behaviour, as the environment provides it.
    function automatic logic [15:0] alu_fn(input logic [3:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
        case (op)
            4'h0:    return a + b;
            4'h4:    return a ^ b;
            4'h6:    return a | b;
            4'h7:    return a & b;
            4'h8:    return {15'd0, a == b};
            4'h9:    return {15'd0, a != b};
            4'hA:    return a - b;
            4'hC:    return {15'd0, $signed(a) <  $signed(b)};
            4'hD:    return {15'd0, $signed(a) >= $signed(b)};
            4'hE:    return {15'd0, a <  b};
            4'hF:    return {15'd0, a >= b};
            default: return 16'hDEAD;
        endcase
    endfunction

    always_comb alu_out = alu_fn(alu_sel, alu_a, alu_b);

    function automatic bit tb_legal(input logic [3:0] op);
        foreach (legal_ops[i]) begin
            if (legal_ops[i] == op) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Expected response packed as {result, zero, err, tag}.
    function automatic logic [31:0] model_rsp(input logic [3:0] op,
                                              input logic [15:0] a,
                                              input logic [15:0] b,
                                              input logic [3:0] tag);
        logic [15:0] res;
        res = tb_legal(op) ? alu_fn(op, a, b) : 16'h0000;
        return {10'd0, res, res == 16'h0000, !tb_legal(op), tag};
    endfunction

    function automatic logic [31:0] dut_rsp();
        return {10'd0, rsp_result, rsp_zero, rsp_err, rsp_tag};
    endfunction

    alu_issue_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .TAG_W      (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_tag    (cmd_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .rsp_tag    (rsp_tag)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .stat_ops   (stat_ops)
`endif
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // One command into an idle, empty block; checks latency and fields.
    task automatic issue_one(input vec_t v, input int idx);
        logic [3:0] exp_sel;
        exp_sel   = v.err ? 4'h0 : v.op;
        cmd_op    = v.op;
        cmd_a     = v.a;
        cmd_b     = v.b;
        cmd_tag   = v.tag;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        check($sformatf("vec%0d_ready", idx), cmd_ready, 1);
        step();                                   // push edge k
        cmd_valid = 1'b0;
        check($sformatf("vec%0d_valid_k", idx), rsp_valid, 0);
        step();                                   // edge k+1: ISSUE
        check($sformatf("vec%0d_valid_k1", idx), rsp_valid, 0);
        check($sformatf("vec%0d_issue_sel", idx), alu_sel, exp_sel);
        check($sformatf("vec%0d_issue_ab", idx), {alu_a, alu_b}, {v.a, v.b});
        step();                                   // edge k+2: RESP
        check($sformatf("vec%0d_valid_k2", idx), rsp_valid, 1);
        check($sformatf("vec%0d_rsp", idx), dut_rsp(),
              {10'd0, v.res, v.zero, v.err, v.tag});
        check($sformatf("vec%0d_sel_held", idx), alu_sel, exp_sel);
        step();                                   // handshake edge
        check($sformatf("vec%0d_idle", idx), rsp_valid, 0);
    endtask

    // Fill the FIFO with rsp_ready low, then drain and check order/rate.
    task automatic fill_and_drain();
        int tags [$];
        int hs_cyc [$];
        bit acc;
        rsp_ready = 1'b0;
        cmd_op    = 4'h0;
        cmd_a     = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_b     = 16'(i);
            cmd_tag   = 4'(i);
            check($sformatf("fill_ready_%0d", i), cmd_ready, 1);
            step();
        end
        check("fill_full_ready", cmd_ready, 0);
        cmd_b   = 16'd5;
        cmd_tag = 4'd5;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("fill_stall_%0d", i), cmd_ready, 0);
            step();
        end
        check("fill_head_valid", rsp_valid, 1);
        check("fill_head_tag", rsp_tag, 0);
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && tags.size() < 6; cyc++) begin
            if (rsp_valid && rsp_ready) begin
                check($sformatf("drain_tag_%0d", tags.size()), rsp_tag,
                      tags.size());
                check($sformatf("drain_res_%0d", tags.size()), rsp_result,
                      32'h0100 + tags.size());
                tags.push_back(int'(rsp_tag));
                hs_cyc.push_back(cyc);
            end
            acc = cmd_valid && cmd_ready;
            step();
            if (acc) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        check("drain_count", tags.size(), 6);
        for (int i = 1; i < hs_cyc.size(); i++) begin
            check($sformatf("drain_gap_%0d", i), hs_cyc[i] - hs_cyc[i-1], 2);
        end
        step();
        check("drain_idle", rsp_valid, 0);
    endtask

    // Random stream against a queue of expected responses.
    task automatic random_stream(input int cycles);
        logic [31:0] sb [$];
        logic [31:0] snap;
        bit          held;
        bit          acc;
        bit          hs;
        held = 1'b0;
        snap = '0;
        for (int c = 0; c < cycles + 400; c++) begin
            if (c < cycles) begin
                cmd_valid = ($urandom_range(0, 1) == 1);
                cmd_op    = 4'($urandom_range(0, 15));
                cmd_a     = 16'($urandom);
                cmd_b     = ($urandom_range(0, 3) == 0) ? cmd_a : 16'($urandom);
                cmd_tag   = 4'($urandom_range(0, 15));
                rsp_ready = ($urandom_range(0, 3) != 0);
            end else begin
                cmd_valid = 1'b0;
                rsp_ready = 1'b1;
                if (sb.size() == 0 && !rsp_valid) break;
            end
            acc = cmd_valid && cmd_ready;
            hs  = rsp_valid && rsp_ready;
            if (hs) begin
                check("rnd_rsp_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    check("rnd_rsp", dut_rsp(), sb.pop_front());
                end
            end
            if (acc) sb.push_back(model_rsp(cmd_op, cmd_a, cmd_b, cmd_tag));
            held = rsp_valid && !rsp_ready;
            snap = dut_rsp();
            step();
            if (held) begin
                check("rnd_hold_valid", rsp_valid, 1);
                check("rnd_hold_stable", dut_rsp(), snap);
            end
        end
        check("rnd_drained", sb.size(), 0);
        check("rnd_final_idle", rsp_valid, 0);
    endtask

    initial begin
        vecs[0]  = '{4'h0, 16'h0003, 16'h0005, 4'd1,  16'h0008, 1'b0, 1'b0};
        vecs[1]  = '{4'hA, 16'h1234, 16'h1234, 4'd2,  16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{4'h3, 16'h1111, 16'h2222, 4'd7,  16'h0000, 1'b1, 1'b1};
        vecs[3]  = '{4'h4, 16'hF0F0, 16'h0FF0, 4'd3,  16'hFF00, 1'b0, 1'b0};
        vecs[4]  = '{4'h6, 16'h0000, 16'h0000, 4'd4,  16'h0000, 1'b1, 1'b0};
        vecs[5]  = '{4'h7, 16'hFF00, 16'h0F0F, 4'd5,  16'h0F00, 1'b0, 1'b0};
        vecs[6]  = '{4'h8, 16'h5555, 16'h5555, 4'd6,  16'h0001, 1'b0, 1'b0};
        vecs[7]  = '{4'h9, 16'h5555, 16'h5555, 4'd8,  16'h0000, 1'b1, 1'b0};
        vecs[8]  = '{4'hC, 16'h8000, 16'h0001, 4'd9,  16'h0001, 1'b0, 1'b0};
        vecs[9]  = '{4'hE, 16'h8000, 16'h0001, 4'd10, 16'h0000, 1'b1, 1'b0};
        vecs[10] = '{4'hD, 16'h8000, 16'h0001, 4'd11, 16'h0000, 1'b1, 1'b0};
        vecs[11] = '{4'hF, 16'h8000, 16'h0001, 4'd12, 16'h0001, 1'b0, 1'b0};
        vecs[12] = '{4'hB, 16'h00FF, 16'h0001, 4'd15, 16'h0000, 1'b1, 1'b1};
        vecs[13] = '{4'h0, 16'hFFFF, 16'h0001, 4'd14, 16'h0000, 1'b1, 1'b0};

        // Reset values.
        step();
        step();
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp", dut_rsp(), 0);
        check("rst_alu", {alu_a, alu_b, alu_sel}, 0);
`ifdef ALU_ISSUE_STATS_EN
        check("rst_stat_ops", stat_ops, 0);
`endif
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) issue_one(vecs[i], i);

        fill_and_drain();

        random_stream(2000);

        // Reset while in RESP with three commands queued.
        rsp_ready = 1'b0;
        cmd_op    = 4'h0;
        cmd_a     = 16'h0042;
        cmd_b     = 16'h0001;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            cmd_tag   = 4'(i + 8);
            step();
        end
        cmd_valid = 1'b0;
        step();
        check("mid_pre_valid", rsp_valid, 1);
        check("mid_pre_ready", cmd_ready, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_rsp", dut_rsp(), 0);
        check("mid_rst_alu", {alu_a, alu_b, alu_sel}, 0);
        step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                if (rsp_valid) seen++;
                step();
            end
            check("mid_no_stale", seen, 0);
        end
        issue_one(vecs[0], 100);

`ifdef ALU_ISSUE_STATS_EN
        apply_reset();
        check("stat_after_rst", stat_ops, 0);
        begin
            int n;
            n         = 0;
            cmd_op    = 4'h0;
            cmd_a     = 16'h0001;
            cmd_b     = 16'h0002;
            cmd_tag   = 4'd3;
            cmd_valid = 1'b1;
            rsp_ready = 1'b1;
            for (int c = 0; c < 140000 && n < 32'h10002; c++) begin
                if (rsp_valid && rsp_ready) n++;
                step();
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b0;
            check("stat_hs_count", n, 32'h10002);
            check("stat_wrap", stat_ops, 16'h0002);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
- REQ-001: Parameter FIFO_DEPTH, default 4, command FIFO entries; SHALL be a power of two, 2..16.
- REQ-002: Parameter TAG_W, default 4, command/response tag width.
- REQ-003: The block SHALL use one clock, and its reset SHALL be asynchronous and active-low; ports `clk` and `rst_n` come first.
- REQ-004: The port list SHALL be as follows.
  - clk  in  1  system clock
  - rst_n  in  1  asynchronous active-low reset
  - cmd_valid  in  1  command offered
  - cmd_ready  out  1  command FIFO can accept
  - cmd_op  in  4  ALU opcode
  - cmd_a, cmd_b  in  16  operands
  - cmd_tag  in  TAG_W  command tag
  - alu_a, alu_b  out  16  operands driven to the external ALU
  - alu_sel  out  4  opcode driven to the external ALU
  - alu_out  in  16  combinational ALU result
  - rsp_valid  out  1  response held
  - rsp_ready  in  1  consumer accepts the response
  - rsp_result  out  16  captured result
  - rsp_zero  out  1  rsp_result equals 0
  - rsp_err  out  1  opcode was illegal
  - rsp_tag  out  TAG_W  tag of the command
  - stat_ops  out  16  completed-op count (present only with ALU_ISSUE_STATS_EN)

Function
- REQ-005: Legal opcodes SHALL be 0000 ADD, 0100 XOR, 0110 OR, 0111 AND, 1000 EQ, 1001 NE, 1010 SUB, 1100 SLT, 1101 SGE, 1110 ULT and 1111 UGE; every other opcode is illegal.
- REQ-006: A command SHALL be pushed on any edge where cmd_valid && cmd_ready; cmd_ready = !full, with no push-through when full even if a pop occurs in the same cycle.
- REQ-007: The FSM SHALL have the states IDLE, ISSUE and RESP.
- REQ-008: From IDLE, if the FIFO is non-empty, the block SHALL pop the head into the operand/op/tag registers and go to ISSUE; otherwise it stays in IDLE.
- REQ-009: In ISSUE, alu_a/alu_b/alu_sel SHALL be driven from the registers; at the end of ISSUE (one cycle), rsp_result SHALL capture alu_out, rsp_zero SHALL capture (alu_out==0), and the FSM SHALL go to RESP.
- REQ-010: For an illegal opcode, ISSUE SHALL drive alu_sel=0000, capture rsp_result=0, rsp_zero=1 and rsp_err=1; legal opcodes capture rsp_err=0.
- REQ-011: Outside ISSUE, alu_a/alu_b/alu_sel SHALL hold their last driven values.
- REQ-012: In RESP, rsp_valid SHALL be 1, and all rsp_* outputs SHALL be stable until rsp_valid && rsp_ready.
- REQ-013: On a response handshake, the block SHALL pop the head and go directly to ISSUE if the FIFO is non-empty, else go to IDLE; back-to-back throughput is one op per 2 cycles.
- REQ-014: Latency SHALL be 2 cycles: a command pushed at edge k into an empty, idle block gives rsp_valid=1 after edge k+2.
- REQ-015: The FIFO pointers SHALL wrap modulo FIFO_DEPTH, and an occupancy counter of width log2(FIFO_DEPTH)+1 SHALL distinguish full from empty.
- REQ-016: Commands SHALL be answered strictly in push order, and tags are never reordered.

Reset
- REQ-017: Asserting rst_n low SHALL immediately force:
  - FSM to IDLE and FIFO empty (cmd_ready=1);
  - rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0, rsp_tag=0;
  - alu_a=0, alu_b=0, alu_sel=0, stat_ops=0.
- REQ-018: Reset mid-operation SHALL discard all queued and in-flight commands without emitting any response.

Configuration
- REQ-019: With macro ALU_ISSUE_STATS_EN defined, port stat_ops SHALL exist and increment by 1, wrapping at 16 bits, on each response handshake.
- REQ-020: Without ALU_ISSUE_STATS_EN, the port and counter SHALL be absent, and all other behaviour is identical.

Structure
- REQ-021: Package alu_issue_pkg SHALL hold:
  - the 4-bit opcode localparams for REQ-005;
  - the FSM state enum typedef;
  - a command struct typedef holding op, a, b and tag.
- REQ-022: The FIFO SHALL be a sub-module, alu_cmd_fifo, parameterised by depth and payload width; the FSM and capture logic stay in alu_issue_ctrl.

Verification
- REQ-023: The bench SHALL cover these directed scenarios:
  - Push ADD a=0x0003, b=0x0005, tag=1 with rsp_ready=1 -> rsp_valid 2 cycles after the push, rsp_result=0x0008, rsp_zero=0, rsp_err=0, rsp_tag=1.
  - Push SUB a=0x1234, b=0x1234 -> rsp_result=0x0000, rsp_zero=1.
  - Push op=0011 (illegal) with tag=7 -> alu_sel=0000 during ISSUE, then rsp_result=0, rsp_zero=1, rsp_err=1, rsp_tag=7.
  - Hold rsp_ready=0 and push 5 commands at depth 4 -> one command is in flight and 4 are queued, so cmd_ready=0 after the 5th push; a 6th offer stalls; releasing rsp_ready drains the tags in order 0..5 at one response per 2 cycles.
  - Assert rst_n low while in RESP with 3 queued commands -> rsp_valid=0 and cmd_ready=1 immediately, and no stale responses follow deassertion.
  - With ALU_ISSUE_STATS_EN, complete 0x10002 ops -> stat_ops=0x0002 (wrap).
